// File: rtl/lut_frac_pkg.sv
// lut_frac_pkg: shared types and size helpers for the fracturable LUT.
package lut_frac_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} lf_state_e;
    function automatic int cfg_w(input int inputs);
        return 2 * (2 ** inputs) + 1;
    endfunction
    function automatic int cnt_w(input int inputs);
        return $clog2(cfg_w(inputs) + 1);
    endfunction
endpackage

// File: rtl/lut_frac_mem.sv
// lut_mem: read-only MEM_SIZE-bit mux indexed by an INPUTS-bit address.
module lut_mem #(
    parameter int INPUTS = 4,
    localparam int MEM_SIZE = 2 ** INPUTS
) (
    input  logic [MEM_SIZE-1:0] i_mem,
    input  logic [INPUTS-1:0]   i_addr,
    output logic                o_q
);
    assign o_q = i_mem[i_addr];
endmodule

// File: rtl/lut_frac_scan.sv
// lut_frac_scan: dual/chained LUT with shadow-then-commit serial configuration.
// Define LUT_OUT_REG_EN to register out on config_clk.
module lut_frac_scan
    import lut_frac_pkg::*;
#(
    parameter int INPUTS = 4,
    localparam int MEM_SIZE = 2 ** INPUTS
) (
    input  logic                  config_clk,
    input  logic                  config_rst_n,
    input  logic [2*INPUTS-1:0]   addr,
    output logic [1:0]            out,
    input  logic                  config_en,
    input  logic                  config_in,
    input  logic                  config_abort,
    output logic                  config_ready,
    output logic                  config_done
);
    localparam int CFG_W = cfg_w(INPUTS);
    localparam int CNT_W = cnt_w(INPUTS);

    lf_state_e          r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [CFG_W-1:0]   r_shadow, r_active;
    logic               w_accept, w_first, w_second, w_sel;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        config_ready = r_state != COMMIT;
        config_done  = r_state == COMMIT;
        w_accept     = config_en && config_ready && !config_abort;
        if (r_state == COMMIT || config_abort) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (w_accept) begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = (w_cnt_nxt == CNT_W'(CFG_W)) ? COMMIT : SHIFT;
        end
    end

    // Reset leaves split=1 with empty memories so both outputs read 0.
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_active <= {1'b1, {(CFG_W-1){1'b0}}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) r_shadow <= {r_shadow[CFG_W-2:0], config_in};
            if (r_state == COMMIT) r_active <= r_shadow;
        end
    end

    lut_mem #(.INPUTS(INPUTS)) u_first (
        .i_mem  (r_active[2*MEM_SIZE-1:MEM_SIZE]),
        .i_addr (addr[2*INPUTS-1:INPUTS]),
        .o_q    (w_first)
    );

    // Chained mode steers the second LUT's top address bit from the first LUT.
    assign w_sel = r_active[CFG_W-1] ? addr[INPUTS-1] : w_first;

    lut_mem #(.INPUTS(INPUTS)) u_second (
        .i_mem  (r_active[MEM_SIZE-1:0]),
        .i_addr ({w_sel, addr[INPUTS-2:0]}),
        .o_q    (w_second)
    );

`ifdef LUT_OUT_REG_EN
    logic [1:0] r_out;
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) r_out <= '0;
        else r_out <= {w_first, w_second};
    end
    assign out = r_out;
`else
    assign out = {w_first, w_second};
`endif
endmodule

// File: tb/tb_lut_frac_scan.sv
// tb_lut_frac_scan: table-driven and randomized checks of lut_frac_scan (INPUTS=4).
module tb_lut_frac_scan;
    localparam int CFG_W = 33;

    logic       config_clk = 0, config_rst_n = 0;
    logic [7:0] addr = 0;
    logic [1:0] out;
    logic       config_en = 0, config_in = 0, config_abort = 0;
    logic       config_ready, config_done;

    int n_tests = 0, n_fail = 0;
    logic [CFG_W-1:0] active_m;
    logic [CFG_W-1:0] cfgs [2];
    logic [CFG_W-1:0] rst_cfg;

    typedef struct {int which; logic [7:0] a; logic [1:0] exp;} vec_t;
    vec_t vecs [10];

    lut_frac_scan #(.INPUTS(4)) dut (
        .config_clk   (config_clk),
        .config_rst_n (config_rst_n),
        .addr         (addr),
        .out          (out),
        .config_en    (config_en),
        .config_in    (config_in),
        .config_abort (config_abort),
        .config_ready (config_ready),
        .config_done  (config_done)
    );

    always #5 config_clk = ~config_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Reference: first LUT indexed by addr[7:4]; second by {sel, addr[2:0]}.
    function automatic logic [1:0] model(input logic [CFG_W-1:0] cfg, input logic [7:0] a);
        int hi, lo, idx;
        logic f, s;
        hi  = int'(a[7:4]);
        lo  = int'(a[3:0]);
        f   = cfg[16 + hi];
        s   = cfg[32] ? a[3] : f;
        idx = (s ? 8 : 0) + lo % 8;
        return {f, cfg[idx]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge config_clk);
        #1;
    endtask

    task automatic apply_addr(input logic [7:0] a);
        addr = a;
`ifdef LUT_OUT_REG_EN
        tick();
`else
        #1;
`endif
    endtask

    // Shift the first n bits of cfg MSB-first with random idle gaps; n==33 expects a commit.
    task automatic send_cfg(input logic [CFG_W-1:0] cfg, input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) begin
                config_en = 0;
                config_in = 1'($urandom);
                tick();
                chk("gap_done", config_done, 0);
            end
            config_en = 1;
            config_in = cfg[CFG_W-1-i];
            tick();
            config_en = 0;
            if (i < CFG_W - 1) begin
                chk("load_done", config_done, 0);
                chk("load_ready", config_ready, 1);
                chk("load_out_hold", out, model(active_m, addr));
            end
        end
        if (n == CFG_W) begin
            chk("commit_done", config_done, 1);
            chk("commit_ready", config_ready, 0);
            chk("commit_out_hold", out, model(active_m, addr));
            config_en = 1;
            config_in = ~cfg[0];
            tick();
            config_en = 0;
            chk("post_done", config_done, 0);
            chk("post_ready", config_ready, 1);
            active_m = cfg;
        end
    endtask

    initial begin
        cfgs[0] = {1'b1, 16'h8000, 16'h0001};
        cfgs[1] = {1'b0, 16'h8000, 16'hFF00};
        rst_cfg = {1'b1, 32'h0};
        active_m = rst_cfg;
        vecs = '{
            '{0, 8'hF0, 2'b11}, '{0, 8'h00, 2'b01}, '{0, 8'h80, 2'b01},
            '{0, 8'h08, 2'b00}, '{0, 8'hF8, 2'b10},
            '{1, 8'hF0, 2'b11}, '{1, 8'hE0, 2'b00}, '{1, 8'h0F, 2'b00},
            '{1, 8'hFF, 2'b11}, '{1, 8'h1A, 2'b00}
        };

        tick();
        chk("rst_out", out, 0);
        chk("rst_ready", config_ready, 1);
        chk("rst_done", config_done, 0);
        config_rst_n = 1;
        tick();
        chk("rel_out", out, 0);
        chk("rel_ready", config_ready, 1);
        chk("rel_done", config_done, 0);
        chk("rel_split", dut.r_active[CFG_W-1], 1);

        foreach (vecs[i]) begin
            if (active_m !== cfgs[vecs[i].which]) send_cfg(cfgs[vecs[i].which], CFG_W);
            apply_addr(vecs[i].a);
            chk($sformatf("vec%0d", i), out, vecs[i].exp);
        end

        // Abort with a same-cycle enable; old chained function must survive.
        apply_addr(8'h00);
        send_cfg(cfgs[0], 10);
        config_abort = 1;
        config_en = 1;
        config_in = 1;
        tick();
        config_abort = 0;
        config_en = 0;
        chk("abort_done", config_done, 0);
        chk("abort_ready", config_ready, 1);
        chk("abort_out_old", out, 2'b00);
        send_cfg(cfgs[0], CFG_W);
        apply_addr(8'h00);
        chk("abort_out_new", out, 2'b01);

        // Reset partway through a load.
        send_cfg(cfgs[1], 20);
        #2;
        config_rst_n = 0;
        #1;
        active_m = rst_cfg;
        chk("midrst_out", out, 2'b00);
        chk("midrst_ready", config_ready, 1);
        chk("midrst_done", config_done, 0);
        tick();
        config_rst_n = 1;
        tick();
        chk("midrst_rel_done", config_done, 0);
        send_cfg(cfgs[1], CFG_W);
        apply_addr(8'hF0);
        chk("midrst_new_f0", out, 2'b11);
        apply_addr(8'hE0);
        chk("midrst_new_e0", out, 2'b00);

        for (int k = 0; k < 5; k++) begin
            logic [CFG_W-1:0] c;
            c = {1'($urandom), 32'($urandom)};
            send_cfg(c, CFG_W);
            for (int j = 0; j < 12; j++) begin
                apply_addr(8'($urandom));
                chk($sformatf("rand%0d_%0d", k, j), out, model(active_m, addr));
            end
        end

`ifdef LUT_OUT_REG_EN
        send_cfg(cfgs[0], CFG_W);
        apply_addr(8'h00);
        tick();
        chk("reg_before", out, 2'b01);
        addr = 8'hF0;
        #1;
        chk("reg_hold", out, 2'b01);
        tick();
        chk("reg_after", out, 2'b11);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lut_frac_scan.md
LUT_FRAC_SCAN -- requirements
Module: lut_frac_scan

Interface
REQ-001 SHALL have parameter INPUTS, default 4: input count of each sub-LUT, legal range 2..6.
REQ-002 SHALL have parameter MEM_SIZE, default 2**INPUTS: bits per sub-LUT, fixed by INPUTS and not overridable.
REQ-003 SHALL derive CFG_W = 2*MEM_SIZE+1: total configuration bits, where the MSB is the split bit.
REQ-004 SHALL have port config_clk  in  1: the single clock, used for both configuration and the optional output register.
REQ-005 SHALL have port config_rst_n  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port addr  in  2*INPUTS: addr[2*INPUTS-1:INPUTS] feeds the first LUT; addr[INPUTS-1:0] feeds the second LUT.
REQ-007 SHALL have port out  out  2: out[1] is the first LUT result; out[0] is the second LUT result.
REQ-008 SHALL have port config_en  in  1: marks config_in as a valid serial bit in this cycle.
REQ-009 SHALL have port config_in  in  1: serial configuration bit, first bit sent is the MSB.
REQ-010 SHALL have port config_abort  in  1: discards a partial load.
REQ-011 SHALL have port config_ready  out  1: block accepts config_en this cycle.
REQ-012 SHALL have port config_done  out  1: one-cycle pulse when a new configuration becomes active.

Function
REQ-013 SHALL hold the configuration in two stores: a shadow shift register (CFG_W bits) and an active register (CFG_W bits); only the active register drives the LUT outputs.
REQ-014 SHALL, when config_en=1 and config_ready=1, shift the shadow left by one (shadow <= {shadow[CFG_W-2:0], config_in}) and increment the bit counter.
REQ-015 SHALL use FSM states IDLE (counter 0), SHIFT (counter 1..CFG_W-1) and COMMIT.
REQ-016 SHALL transition IDLE->SHIFT on the first accepted bit, and SHIFT->COMMIT on the accepted bit that brings the counter to CFG_W.
REQ-017 SHALL, in COMMIT (exactly one cycle), copy shadow to active, pulse config_done=1, hold config_ready=0, clear the counter and return to IDLE.
REQ-018 SHALL ignore config_en whenever config_ready=0.
REQ-019 SHALL, on config_abort=1 in IDLE or SHIFT, clear the counter and go to IDLE with the active register unchanged; abort takes priority over a same-cycle config_en; abort during COMMIT is ignored.
REQ-020 SHALL compute first_out = active[2*MEM_SIZE-1:MEM_SIZE] indexed by addr[2*INPUTS-1:INPUTS].
REQ-021 SHALL compute sel = split ? addr[INPUTS-1] : first_out, where split = active[CFG_W-1].
REQ-022 SHALL compute second_out = active[MEM_SIZE-1:0] indexed by {sel, addr[INPUTS-2:0]}.
REQ-023 SHALL, with split=0 (chained), make out[0] a (2*INPUTS-1)-input function, while out[1] still presents first_out.
REQ-024 SHALL make LUT read paths combinational from addr and the active register; a commit affects out in the cycle after COMMIT.

Reset
REQ-025 SHALL, on config_rst_n=0 and asynchronously, clear the active memories to 0, set split=1, clear the shadow and counter, and set state=IDLE.
REQ-026 SHALL, during reset, drive out=2'b00, config_done=0 and config_ready=1 (ready also =1 after release).
REQ-027 SHALL, on reset mid-load or mid-commit, discard the partial load and leave no commit.

Configuration
REQ-028 SHALL, with LUT_OUT_REG_EN defined, register out on config_clk (reset 2'b00, one cycle of latency from addr).
REQ-029 SHALL, with LUT_OUT_REG_EN undefined, drive out combinationally.

Structure
REQ-030 SHALL place the CFG_W derivation, the counter width $clog2(CFG_W+1) and the FSM state enum in the shared package lut_frac_pkg.
REQ-031 SHALL use one sub-module, lut_mem: a MEM_SIZE-bit read-only mux indexed by an INPUTS-bit address, instantiated twice.

Verification (INPUTS=4, CFG_W=33)
REQ-032 SHALL check: reset -> out=2'b00, config_ready=1, config_done=0, split=1.
REQ-033 SHALL check: shift 1, 16'h8000, 16'h0001 (33 bits) -> config_done pulses exactly one cycle after bit 33, config_ready=0 for that cycle; then addr=8'hF0 -> out=2'b11, addr=8'h00 -> out=2'b01.
REQ-034 SHALL check: shift 0, 16'h8000, 16'hFF00 -> addr=8'hF0 gives out=2'b11, addr=8'hE0 gives out=2'b00 (chained path).
REQ-035 SHALL check: 10 bits, then config_abort with config_en=1 in the same cycle, then a full 33-bit load -> no done pulse before the full load, and the old function holds until the commit.
REQ-036 SHALL check: config_rst_n low at bit 20 of a load -> out=2'b00 immediately; after release, a fresh 33-bit load commits correctly.
REQ-037 SHALL check: with LUT_OUT_REG_EN defined, change addr 8'h00->8'hF0 after the REQ-033 config -> out changes 01->11 one config_clk later.
